mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer for a single shared memory port used by the processor's instruction fetch and its data load/store path. It allows a single-port, variable-latency memory to replace the separate instruction memory and data memory. It sits between the fetch/execute stages and the memory. It serialises requests with round-robin arbitration, holds the memory handshake until acknowledge, returns read data with a one-cycle ack pulse, and aborts a transaction that exceeds a wait limit.

## Interface
- AW, 8: address width (word address, matches pc[7:0] fetch indexing)
- DW, 32: data width
- WAIT_MAX, 15: maximum BUSY cycles without m_ack before abort (1..255)
- clk  in  1  clock, all logic on rising edge
- rstd  in  1  reset; synchronous, active-high
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  AW  fetch address, stable while i_req
- i_ack  out  1  one-cycle pulse: fetch done, i_rdata valid
- i_rdata  out  DW  fetched instruction
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_wen  in  4  byte write enables (store only)
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle pulse: data access done
- d_rdata  out  DW  load data
- err  out  1  high with i_ack/d_ack when the transaction timed out
- m_req  out  1  memory request, held until m_ack
- m_we, m_wen[3:0], m_addr[AW], m_wdata[DW]  out  memory command, stable while m_req
- m_rdata  in  DW  memory read data, valid with m_ack
- m_ack  in  1  memory completion, single cycle
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, BUSY, RESP. Owner register: I=0, D=1. last_owner register resets to D.
- IDLE:
  - Only i_req set: owner=I. Only d_req set: owner=D. Both set: owner = ~last_owner.
  - Latch the winner's command. Go to BUSY, clear the wait counter.
  - Fetch commands are driven with m_we=0 and m_wen=0.
- BUSY:
  - m_req=1 and the command is driven from the latched registers.
  - m_ack: capture m_rdata, err=0, go to RESP.
  - No m_ack: increment the counter. If the counter reaches WAIT_MAX with no m_ack, capture 0, set err=1, go to RESP.
- RESP:
  - Pulse the owner's ack with rdata and err. Set last_owner=owner. Go to IDLE.
- m_ack outside BUSY is ignored.
- A requester dropping req during BUSY has no effect: the transaction completes and ack still pulses.
- A requester may keep req high through its ack cycle to start a new transaction; it is re-arbitrated in the following IDLE cycle.
- i_rdata/d_rdata hold their last captured value between acks. Store acks return the m_rdata captured.

## Timing
- All outputs are registered.
- Reset values: i_ack=d_ack=err=m_req=busy=0, m_we=0, m_wen=0, m_addr=0, m_wdata=0, i_rdata=d_rdata=0, state=IDLE, counter=0, last_owner=D.
- A request seen in cycle 0 (IDLE) gives m_req high from cycle 1.
- m_ack in cycle k gives the ack pulse in cycle k+1, then IDLE in cycle k+2.
- Minimum transaction is 3 cycles (m_ack in the first BUSY cycle). Back-to-back throughput is one transaction per 3 cycles.
- Timeout: err/ack occur in cycle WAIT_MAX+2 after the request cycle.
- When both requesters stay asserted, grants strictly alternate I, D, I, D…
- rstd asserted in any state (including mid-BUSY with m_req high) returns everything to reset values on the next edge. m_req drops without waiting for m_ack, and no ack is issued.

## Structure
- Shared constants: FSM state encodings (IDLE=2'd0, BUSY=2'd1, RESP=2'd2), owner codes (OWN_I=1'b0, OWN_D=1'b1). These go in the shared definitions include used by the other processor blocks.
- Sub-module mem_wait_timer: 8-bit counter with clear/enable inputs and an expired output at WAIT_MAX.
- The rest is a single module.

## Test plan
- Reset mid-BUSY (i_req=1, m_req high, no m_ack), rstd=1 for one edge: next cycle m_req=0, busy=0, no i_ack. Then d_req alone: granted first.
- i_req alone with i_addr=8'h04, memory acks in the first BUSY cycle with m_rdata=32'h8C220000: m_req high in cycle 1 only, i_ack with i_rdata=32'h8C220000 in cycle 2, err=0.
- d_req store: d_addr=8'h10, d_wdata=32'hDEADBEEF, d_wen=4'b0011, m_ack after 3 cycles. Required: m_we=1, m_wen=4'b0011, and the command stays stable for the full BUSY period; d_ack follows one cycle after m_ack.
- i_req and d_req high together from reset, memory acks immediately: grants go I, D, I, D. There are exactly 2 i_ack and 2 d_ack pulses in 12 cycles.
- WAIT_MAX=4, d_req load, m_ack never arrives: d_ack=1, err=1, d_rdata=0 in cycle 6. A late m_ack in IDLE is then ignored.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the shared memory port arbiter: FSM state
// encodings, owner codes, timer width and the round-robin pick.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   localparam int unsigned TIMER_W = 8;

   // Single requester wins outright; a tie goes to whoever was not served last.
   function automatic owner_e pick_owner(input logic i_req, input logic d_req,
                                         input owner_e last_owner);
      if (i_req && d_req)
         return (last_owner == OWN_I) ? OWN_D : OWN_I;
      else if (d_req)
         return OWN_D;
      else
         return OWN_I;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side handshake signals around the
// arbiter. slave = arbiter view, master = view of the surrounding logic.
interface mem_port_arbiter_if #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 32
);
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_ack;
   logic [DW-1:0] i_rdata;

   logic          d_req;
   logic          d_we;
   logic [3:0]    d_wen;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_ack;
   logic [DW-1:0] d_rdata;

   logic          err;
   logic          busy;

   logic          m_req;
   logic          m_we;
   logic [3:0]    m_wen;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;
   logic          m_ack;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_wen, d_addr, d_wdata, m_rdata, m_ack,
      output i_ack, i_rdata, d_ack, d_rdata, err, busy,
             m_req, m_we, m_wen, m_addr, m_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_wen, d_addr, d_wdata, m_rdata, m_ack,
      input  i_ack, i_rdata, d_ack, d_rdata, err, busy,
             m_req, m_we, m_wen, m_addr, m_wdata
   );
endinterface

// File: rtl/mem_port_arbiter_wait_timer.sv
// Wait counter for the BUSY state: cleared outside BUSY, counts cycles
// without m_ack, flags expiry when the count reaches WAIT_MAX.
module mem_wait_timer
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 15
) (
   input  logic clk,
   input  logic rstd,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TIMER_W-1:0] cnt;

   assign expired = (cnt == TIMER_W'(WAIT_MAX));

   // Count enabled cycles, holding at the limit.
   always_ff @(posedge clk) begin
      if (rstd || clr)
         cnt <= '0;
      else if (en && !expired)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer putting instruction fetch and data
// load/store onto one variable-latency memory port, with a wait-limit abort.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 15
) (
   input logic                clk,
   input logic                rstd,
   mem_port_arbiter_if.slave  bus
);

   state_e state;
   owner_e owner;
   owner_e last_owner;
   owner_e grant;

   logic tmr_clr;
   logic tmr_en;
   logic tmr_expired;

   assign grant   = pick_owner(bus.i_req, bus.d_req, last_owner);
   assign tmr_clr = (state != BUSY);
   assign tmr_en  = (state == BUSY) && !bus.m_ack;

   mem_wait_timer #(
      .WAIT_MAX (WAIT_MAX)
   ) u_timer (
      .clk     (clk),
      .rstd    (rstd),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (tmr_expired)
   );

   // Sequencer: arbitrate in IDLE, hold the memory command in BUSY, pulse ack in RESP.
   always_ff @(posedge clk) begin
      if (rstd) begin
         state       <= IDLE;
         owner       <= OWN_I;
         last_owner  <= OWN_D;
         bus.i_ack   <= 1'b0;
         bus.i_rdata <= '0;
         bus.d_ack   <= 1'b0;
         bus.d_rdata <= '0;
         bus.err     <= 1'b0;
         bus.busy    <= 1'b0;
         bus.m_req   <= 1'b0;
         bus.m_we    <= 1'b0;
         bus.m_wen   <= '0;
         bus.m_addr  <= '0;
         bus.m_wdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.i_req || bus.d_req) begin
                  owner     <= grant;
                  state     <= BUSY;
                  bus.m_req <= 1'b1;
                  bus.busy  <= 1'b1;
                  if (grant == OWN_D) begin
                     bus.m_we    <= bus.d_we;
                     bus.m_wen   <= bus.d_we ? bus.d_wen : 4'b0000;
                     bus.m_addr  <= bus.d_addr;
                     bus.m_wdata <= bus.d_wdata;
                  end else begin
                     bus.m_we    <= 1'b0;
                     bus.m_wen   <= '0;
                     bus.m_addr  <= bus.i_addr;
                     bus.m_wdata <= '0;
                  end
               end
            end

            BUSY: begin
               // m_ack takes priority over expiry arriving in the same cycle.
               if (bus.m_ack || tmr_expired) begin
                  state     <= RESP;
                  bus.m_req <= 1'b0;
                  bus.err   <= !bus.m_ack;
                  if (owner == OWN_I) begin
                     bus.i_ack   <= 1'b1;
                     bus.i_rdata <= bus.m_ack ? bus.m_rdata : '0;
                  end else begin
                     bus.d_ack   <= 1'b1;
                     bus.d_rdata <= bus.m_ack ? bus.m_rdata : '0;
                  end
               end
            end

            RESP: begin
               bus.i_ack  <= 1'b0;
               bus.d_ack  <= 1'b0;
               bus.err    <= 1'b0;
               bus.busy   <= 1'b0;
               last_owner <= owner;
               state      <= IDLE;
            end

            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle table for fetch/store/stray-ack
// behaviour, plus sequences for alternation, reset mid-BUSY and timeout.
module tb_mem_port_arbiter;

   typedef struct packed {
      logic        rst;
      logic        i_req;
      logic [7:0]  i_addr;
      logic        d_req;
      logic        d_we;
      logic [3:0]  d_wen;
      logic [7:0]  d_addr;
      logic [31:0] d_wdata;
      logic        m_ack;
      logic [31:0] m_rdata;
   } stim_t;

   typedef struct packed {
      logic        m_req;
      logic        m_we;
      logic [3:0]  m_wen;
      logic [7:0]  m_addr;
      logic [31:0] m_wdata;
      logic        i_ack;
      logic        d_ack;
      logic        err;
      logic        busy;
      logic [31:0] i_rdata;
      logic [31:0] d_rdata;
   } resp_t;

   typedef struct {
      string name;
      stim_t s;
      resp_t e;
   } vec_t;

   logic clk;
   logic rstd;
   int   n_cmp;
   int   n_bad;
   vec_t vecs[$];

   mem_port_arbiter_if #(.AW(8), .DW(32)) bus ();

   mem_port_arbiter #(
      .WAIT_MAX (4)
   ) dut (
      .clk  (clk),
      .rstd (rstd),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic resp_t cur();
      resp_t r;
      r = '{bus.m_req, bus.m_we, bus.m_wen, bus.m_addr, bus.m_wdata,
            bus.i_ack, bus.d_ack, bus.err, bus.busy, bus.i_rdata, bus.d_rdata};
      return r;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input stim_t s);
      rstd        = s.rst;
      bus.i_req   = s.i_req;
      bus.i_addr  = s.i_addr;
      bus.d_req   = s.d_req;
      bus.d_we    = s.d_we;
      bus.d_wen   = s.d_wen;
      bus.d_addr  = s.d_addr;
      bus.d_wdata = s.d_wdata;
      bus.m_ack   = s.m_ack;
      bus.m_rdata = s.m_rdata;
   endtask

   task automatic add(input string nm, input stim_t s, input resp_t e);
      vec_t v;
      v.name = nm;
      v.s    = s;
      v.e    = e;
      vecs.push_back(v);
   endtask

   initial begin
      int    n_i;
      int    n_d;
      int    n_ord;
      logic [1:0] ord [4];
      logic [1:0] got;

      n_cmp = 0;
      n_bad = 0;

      // stim:  rst i_req i_addr d_req d_we d_wen d_addr d_wdata m_ack m_rdata
      // resp:  m_req m_we m_wen m_addr m_wdata i_ack d_ack err busy i_rdata d_rdata
      add("f_req",   '{1'b0,1'b1,8'h04,1'b0,1'b0,4'h0,8'h00,32'h0,1'b0,32'h0},
                     '{1'b0,1'b0,4'h0,8'h00,32'h0,1'b0,1'b0,1'b0,1'b0,32'h0,32'h0});
      add("f_busy",  '{1'b0,1'b1,8'h04,1'b0,1'b0,4'h0,8'h00,32'h0,1'b1,32'h8C220000},
                     '{1'b1,1'b0,4'h0,8'h04,32'h0,1'b0,1'b0,1'b0,1'b1,32'h0,32'h0});
      add("f_ack",   '{1'b0,1'b0,8'h00,1'b0,1'b0,4'h0,8'h00,32'h0,1'b0,32'h0},
                     '{1'b0,1'b0,4'h0,8'h04,32'h0,1'b1,1'b0,1'b0,1'b1,32'h8C220000,32'h0});
      add("f_idle",  '{1'b0,1'b0,8'h00,1'b0,1'b0,4'h0,8'h00,32'h0,1'b0,32'h0},
                     '{1'b0,1'b0,4'h0,8'h04,32'h0,1'b0,1'b0,1'b0,1'b0,32'h8C220000,32'h0});
      add("s_req",   '{1'b0,1'b0,8'h00,1'b1,1'b1,4'h3,8'h10,32'hDEADBEEF,1'b0,32'h0},
                     '{1'b0,1'b0,4'h0,8'h04,32'h0,1'b0,1'b0,1'b0,1'b0,32'h8C220000,32'h0});
      add("s_busy1", '{1'b0,1'b0,8'h00,1'b1,1'b1,4'h3,8'h10,32'hDEADBEEF,1'b0,32'h0},
                     '{1'b1,1'b1,4'h3,8'h10,32'hDEADBEEF,1'b0,1'b0,1'b0,1'b1,32'h8C220000,32'h0});
      add("s_busy2", '{1'b0,1'b0,8'h00,1'b1,1'b1,4'h3,8'h10,32'hDEADBEEF,1'b0,32'h0},
                     '{1'b1,1'b1,4'h3,8'h10,32'hDEADBEEF,1'b0,1'b0,1'b0,1'b1,32'h8C220000,32'h0});
      add("s_busy3", '{1'b0,1'b0,8'h00,1'b1,1'b1,4'h3,8'h10,32'hDEADBEEF,1'b1,32'h00001234},
                     '{1'b1,1'b1,4'h3,8'h10,32'hDEADBEEF,1'b0,1'b0,1'b0,1'b1,32'h8C220000,32'h0});
      add("s_ack",   '{1'b0,1'b0,8'h00,1'b0,1'b0,4'h0,8'h00,32'h0,1'b0,32'h0},
                     '{1'b0,1'b1,4'h3,8'h10,32'hDEADBEEF,1'b0,1'b1,1'b0,1'b1,32'h8C220000,32'h00001234});
      add("stray1",  '{1'b0,1'b0,8'h00,1'b0,1'b0,4'h0,8'h00,32'h0,1'b1,32'hFFFFFFFF},
                     '{1'b0,1'b1,4'h3,8'h10,32'hDEADBEEF,1'b0,1'b0,1'b0,1'b0,32'h8C220000,32'h00001234});
      add("stray2",  '{1'b0,1'b0,8'h00,1'b0,1'b0,4'h0,8'h00,32'h0,1'b0,32'h0},
                     '{1'b0,1'b1,4'h3,8'h10,32'hDEADBEEF,1'b0,1'b0,1'b0,1'b0,32'h8C220000,32'h00001234});
      add("dr_req",  '{1'b0,1'b1,8'h3C,1'b0,1'b0,4'h0,8'h00,32'h0,1'b0,32'h0},
                     '{1'b0,1'b1,4'h3,8'h10,32'hDEADBEEF,1'b0,1'b0,1'b0,1'b0,32'h8C220000,32'h00001234});
      add("dr_drop", '{1'b0,1'b0,8'h00,1'b0,1'b0,4'h0,8'h00,32'h0,1'b0,32'h0},
                     '{1'b1,1'b0,4'h0,8'h3C,32'h0,1'b0,1'b0,1'b0,1'b1,32'h8C220000,32'h00001234});
      add("dr_busy", '{1'b0,1'b0,8'h00,1'b0,1'b0,4'h0,8'h00,32'h0,1'b1,32'h0000ABCD},
                     '{1'b1,1'b0,4'h0,8'h3C,32'h0,1'b0,1'b0,1'b0,1'b1,32'h8C220000,32'h00001234});
      add("dr_ack",  '{1'b0,1'b0,8'h00,1'b0,1'b0,4'h0,8'h00,32'h0,1'b0,32'h0},
                     '{1'b0,1'b0,4'h0,8'h3C,32'h0,1'b1,1'b0,1'b0,1'b1,32'h0000ABCD,32'h00001234});
      add("dr_idle", '{1'b0,1'b0,8'h00,1'b0,1'b0,4'h0,8'h00,32'h0,1'b0,32'h0},
                     '{1'b0,1'b0,4'h0,8'h3C,32'h0,1'b0,1'b0,1'b0,1'b0,32'h0000ABCD,32'h00001234});

      // Reset and reset values
      drive('0);
      rstd = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_vals", 128'(cur()), 128'(resp_t'('0)));

      // Table: fetch, store, stray m_ack in IDLE, requester dropping in BUSY
      foreach (vecs[k]) begin
         drive(vecs[k].s);
         @(negedge clk);
         chk(vecs[k].name, 128'(cur()), 128'(vecs[k].e));
         tick();
      end

      // Both requesters held high from reset, memory acks immediately
      drive('0);
      rstd = 1'b1;
      tick();
      rstd        = 1'b0;
      bus.i_req   = 1'b1;
      bus.i_addr  = 8'h01;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_addr  = 8'h81;
      n_i   = 0;
      n_d   = 0;
      n_ord = 0;
      for (int c = 0; c < 12; c++) begin
         bus.m_ack   = bus.m_req;
         bus.m_rdata = {24'h0, bus.m_addr};
         @(negedge clk);
         if (bus.i_ack) begin
            n_i++;
            if (n_ord < 4) ord[n_ord] = 2'd0;
            n_ord++;
            chk("alt_i_rdata", 128'(bus.i_rdata), 128'(32'h01));
         end
         if (bus.d_ack) begin
            n_d++;
            if (n_ord < 4) ord[n_ord] = 2'd1;
            n_ord++;
            chk("alt_d_rdata", 128'(bus.d_rdata), 128'(32'h81));
         end
         tick();
      end
      drive('0);
      chk("alt_i_count", 128'(n_i), 128'(2));
      chk("alt_d_count", 128'(n_d), 128'(2));
      for (int k = 0; k < 4; k++) begin
         got = (k < n_ord) ? ord[k] : 2'd3;
         chk("alt_order", 128'(got), 128'(k % 2));
      end
      tick();

      // Reset while BUSY with a fetch outstanding, then a lone data load
      bus.i_req  = 1'b1;
      bus.i_addr = 8'h08;
      tick();
      rstd = 1'b1;
      @(negedge clk);
      chk("rmb_mreq_before", 128'(bus.m_req), 128'(1));
      tick();
      rstd        = 1'b0;
      bus.i_req   = 1'b0;
      bus.d_req   = 1'b1;
      bus.d_we    = 1'b0;
      bus.d_addr  = 8'h30;
      @(negedge clk);
      chk("rmb_after", 128'({bus.m_req, bus.busy, bus.i_ack, bus.d_ack}), 128'(4'b0000));
      tick();
      bus.m_ack   = 1'b1;
      bus.m_rdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("rmb_d_grant", 128'({bus.m_req, bus.m_we, bus.m_wen, bus.m_addr}), 128'({1'b1, 1'b0, 4'h0, 8'h30}));
      chk("rmb_no_iack", 128'(bus.i_ack), 128'(0));
      tick();
      bus.m_ack = 1'b0;
      bus.d_req = 1'b0;
      @(negedge clk);
      chk("rmb_d_ack", 128'({bus.d_ack, bus.i_ack, bus.err, bus.d_rdata}), 128'({1'b1, 1'b0, 1'b0, 32'hCAFEF00D}));
      tick();

      // Timeout with WAIT_MAX=4: load issued in cycle 0, abort ack in cycle 6
      bus.d_req  = 1'b1;
      bus.d_we   = 1'b0;
      bus.d_addr = 8'h20;
      tick();
      for (int t = 1; t <= 5; t++) begin
         @(negedge clk);
         chk($sformatf("to_busy_c%0d", t), 128'({bus.m_req, bus.busy, bus.d_ack, bus.err}), 128'(4'b1100));
         tick();
      end
      bus.d_req = 1'b0;
      @(negedge clk);
      chk("to_abort", 128'({bus.d_ack, bus.err, bus.i_ack, bus.m_req, bus.d_rdata}), 128'({4'b1100, 32'h0}));
      tick();
      bus.m_ack   = 1'b1;
      bus.m_rdata = 32'h12345678;
      @(negedge clk);
      chk("to_clear", 128'({bus.d_ack, bus.err, bus.busy, bus.m_req}), 128'(4'b0000));
      tick();
      bus.m_ack = 1'b0;
      for (int t = 0; t < 2; t++) begin
         @(negedge clk);
         chk("late_ack_ignored", 128'({bus.i_ack, bus.d_ack, bus.err, bus.busy, bus.m_req, bus.d_rdata}), 128'({5'b00000, 32'h0}));
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
